// File: rtl/hcf_rr_scheduler.sv
// hcf_rr_scheduler: shares a single HCF engine among NREQ requesters.
// Grants are round-robin from the last served requester. A zero operand is
// resolved locally without using the engine. A watchdog aborts an engine
// operation that never completes.
module hcf_rr_scheduler #(
    parameter int unsigned N       = 8,
    parameter int unsigned NREQ    = 4,
    parameter int unsigned IDW     = 2,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*N-1:0]   req_a,
    input  logic [NREQ*N-1:0]   req_b,
    output logic                resp_valid,
    output logic [IDW-1:0]      resp_id,
    output logic [N-1:0]        resp_hcf,
    output logic                resp_err,
    output logic                busy,
    output logic                eng_start,
    output logic [N-1:0]        eng_in1,
    output logic [N-1:0]        eng_in2,
    output logic                eng_abort,
    input  logic [N-1:0]        eng_hcf,
    input  logic                eng_done
);

    localparam int unsigned WDW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [N-1:0]     a_q, a_d;
    logic [N-1:0]     b_q, b_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [IDW-1:0]   last_q, last_d;
    logic [WDW-1:0]   wd_q, wd_d;
    logic             done_q;
    logic             eng_start_q;
    logic             busy_q;
    logic             resp_valid_q;
    logic [IDW-1:0]   resp_id_q, resp_id_d;
    logic [N-1:0]     resp_hcf_q, resp_hcf_d;
    logic             resp_err_q, resp_err_d;

    logic             found_hi, found_lo;
    logic [IDW-1:0]   idx_hi, idx_lo, gnt_idx;
    logic [N-1:0]     sel_a, sel_b;
    logic             done_rise;

    // Round-robin search: first valid index above last_q, else first valid overall
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        idx_hi   = '0;
        idx_lo   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (req_valid[i]) begin
                if (!found_hi && (i > 32'(last_q))) begin
                    found_hi = 1'b1;
                    idx_hi   = IDW'(i);
                end
                if (!found_lo) begin
                    found_lo = 1'b1;
                    idx_lo   = IDW'(i);
                end
            end
        end
        gnt_idx = found_hi ? idx_hi : idx_lo;
    end

    // Operand mux for the granted requester
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (IDW'(i) == gnt_idx) begin
                sel_a = req_a[i*N +: N];
                sel_b = req_b[i*N +: N];
            end
        end
    end

    // One-hot accept, only while idle; must be same-cycle to complete the handshake
    always_comb begin
        req_ready = '0;
        if ((state_q == S_IDLE) && found_lo) begin
            req_ready = NREQ'(1) << gnt_idx;
        end
    end

    // A done level left over from the previous operation must not count again
    assign done_rise = eng_done & ~done_q;

    // Next-state, datapath updates and the watchdog abort pulse
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        id_d       = id_q;
        last_d     = last_q;
        wd_d       = wd_q;
        resp_id_d  = resp_id_q;
        resp_hcf_d = resp_hcf_q;
        resp_err_d = resp_err_q;
        eng_abort  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (found_lo) begin
                    a_d  = sel_a;
                    b_d  = sel_b;
                    id_d = gnt_idx;
                    if ((sel_a == '0) || (sel_b == '0)) begin
                        state_d    = S_RESP;
                        resp_id_d  = gnt_idx;
                        resp_hcf_d = (sel_a == '0) ? sel_b : sel_a;
                        resp_err_d = (sel_a == '0) && (sel_b == '0);
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                wd_d    = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (done_rise) begin
                    state_d    = S_RESP;
                    resp_id_d  = id_q;
                    resp_hcf_d = eng_hcf;
                    resp_err_d = 1'b0;
                end else if (wd_q == WDW'(TIMEOUT - 1)) begin
                    eng_abort  = 1'b1;
                    state_d    = S_RESP;
                    resp_id_d  = id_q;
                    resp_hcf_d = '0;
                    resp_err_d = 1'b1;
                end else begin
                    wd_d = wd_q + WDW'(1);
                end
            end
            S_RESP: begin
                last_d  = id_q;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; strobes are registered from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            a_q          <= '0;
            b_q          <= '0;
            id_q         <= '0;
            last_q       <= IDW'(NREQ - 1);
            wd_q         <= '0;
            done_q       <= 1'b0;
            eng_start_q  <= 1'b0;
            busy_q       <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_hcf_q   <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            id_q         <= id_d;
            last_q       <= last_d;
            wd_q         <= wd_d;
            done_q       <= eng_done;
            eng_start_q  <= (state_d == S_ISSUE);
            busy_q       <= (state_d != S_IDLE);
            resp_valid_q <= (state_d == S_RESP);
            resp_id_q    <= resp_id_d;
            resp_hcf_q   <= resp_hcf_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign eng_start  = eng_start_q;
    assign eng_in1    = a_q;
    assign eng_in2    = b_q;
    assign busy       = busy_q;
    assign resp_valid = resp_valid_q;
    assign resp_id    = resp_id_q;
    assign resp_hcf   = resp_hcf_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_hcf_rr_scheduler.sv
// Directed bench for hcf_rr_scheduler with a behavioural HCF engine stub.
module tb_hcf_rr_scheduler;

    localparam int N    = 8;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*N-1:0] req_a;
    logic [NREQ*N-1:0] req_b;
    logic              resp_valid;
    logic [IDW-1:0]    resp_id;
    logic [N-1:0]      resp_hcf;
    logic              resp_err;
    logic              busy;
    logic              eng_start;
    logic [N-1:0]      eng_in1;
    logic [N-1:0]      eng_in2;
    logic              eng_abort;
    logic [N-1:0]      eng_hcf;
    logic              eng_done;

    int checks = 0;
    int errors = 0;
    int starts = 0;

    // Engine stub: 0 = done pulse, 1 = done level (drops then re-rises), 2 = never done
    int           stub_mode = 0;
    int           cnt = 0;
    logic         done_r = 1'b0;
    logic [N-1:0] hcf_r = '0;
    logic [N-1:0] pend = '0;

    hcf_rr_scheduler #(.N(N), .NREQ(NREQ), .IDW(IDW), .TIMEOUT(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_id    (resp_id),
        .resp_hcf   (resp_hcf),
        .resp_err   (resp_err),
        .busy       (busy),
        .eng_start  (eng_start),
        .eng_in1    (eng_in1),
        .eng_in2    (eng_in2),
        .eng_abort  (eng_abort),
        .eng_hcf    (eng_hcf),
        .eng_done   (eng_done)
    );

    always #5 clk = ~clk;

    function automatic logic [N-1:0] gcd(input logic [N-1:0] x, input logic [N-1:0] y);
        logic [N-1:0] p = x;
        logic [N-1:0] q = y;
        logic [N-1:0] t;
        while (q != 0) begin
            t = p % q;
            p = q;
            q = t;
        end
        return p;
    endfunction

    // Engine stub behaviour
    always @(posedge clk) begin
        if (eng_start) begin
            starts <= starts + 1;
            pend   <= gcd(eng_in1, eng_in2);
            if (stub_mode != 1) done_r <= 1'b0;
            if (stub_mode != 2) cnt <= 1;
        end else if (cnt != 0) begin
            cnt <= cnt + 1;
            if (stub_mode == 0 && cnt == 3) begin
                done_r <= 1'b1;
                hcf_r  <= pend;
                cnt    <= 0;
            end
            if (stub_mode == 1 && cnt == 4) done_r <= 1'b0;
            if (stub_mode == 1 && cnt == 7) begin
                done_r <= 1'b1;
                hcf_r  <= pend;
                cnt    <= 0;
            end
        end else if (stub_mode == 0) begin
            done_r <= 1'b0;
        end
    end

    assign eng_done = done_r;
    assign eng_hcf  = hcf_r;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [N-1:0] a, input logic [N-1:0] b);
        req_valid[i]     = 1'b1;
        req_a[i*N +: N]  = a;
        req_b[i*N +: N]  = b;
    endtask

    // Sample #1 after each falling edge until requester i is offered ready
    task automatic await_ready(input int i);
        int n = 0;
        logic [NREQ-1:0] exp_oh;
        exp_oh = '0;
        exp_oh[i] = 1'b1;
        #1;
        while (!req_ready[i] && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("ready_onehot", 32'(req_ready), 32'(exp_oh));
    endtask

    task automatic wait_resp(output int n, output int ab_at, output int ab_cnt);
        n = 0;
        ab_at = 0;
        ab_cnt = 0;
        while (n < 64) begin
            @(negedge clk);
            n++;
            if (eng_abort) begin
                ab_at = n;
                ab_cnt++;
            end
            if (resp_valid) break;
        end
        chk("resp_seen", 32'(resp_valid), 1);
    endtask

    // One complete transaction from a single requester
    task automatic xact(input int i, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [N-1:0] exp_hcf, input logic exp_err,
                        input bit bypass, input int exp_lat, input int exp_abort);
        int s0, n, ab_at, ab_cnt;
        @(negedge clk);
        set_req(i, a, b);
        await_ready(i);
        s0 = starts;
        @(negedge clk);
        req_valid[i] = 1'b0;
        if (bypass) begin
            chk("byp_valid", 32'(resp_valid), 1);
            chk("byp_id", 32'(resp_id), 32'(i));
            chk("byp_hcf", 32'(resp_hcf), 32'(exp_hcf));
            chk("byp_err", 32'(resp_err), 32'(exp_err));
            chk("byp_no_start", 32'(eng_start), 0);
            @(negedge clk);
            chk("byp_strobe_1cyc", 32'(resp_valid), 0);
            chk("byp_hold_hcf", 32'(resp_hcf), 32'(exp_hcf));
            chk("byp_start_cnt", 32'(starts), 32'(s0));
        end else begin
            chk("eng_start", 32'(eng_start), 1);
            chk("eng_in1", 32'(eng_in1), 32'(a));
            chk("eng_in2", 32'(eng_in2), 32'(b));
            wait_resp(n, ab_at, ab_cnt);
            chk("latency", 32'(n), 32'(exp_lat));
            chk("abort_cnt", 32'(ab_cnt), (exp_abort != 0) ? 1 : 0);
            chk("abort_at", 32'(ab_at), 32'(exp_abort));
            chk("resp_id", 32'(resp_id), 32'(i));
            chk("resp_hcf", 32'(resp_hcf), 32'(exp_hcf));
            chk("resp_err", 32'(resp_err), 32'(exp_err));
            chk("in_held", 32'(eng_in1), 32'(a));
        end
    endtask

    // Grant i out of the currently raised set, drop it and check its response
    task automatic rr_step(input int i, input logic [N-1:0] exp_hcf);
        int n, ab_at, ab_cnt;
        await_ready(i);
        @(negedge clk);
        req_valid[i] = 1'b0;
        wait_resp(n, ab_at, ab_cnt);
        chk("rr_id", 32'(resp_id), 32'(i));
        chk("rr_hcf", 32'(resp_hcf), 32'(exp_hcf));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, 32'(req_ready), 0);
        chk({tag, "_rvalid"}, 32'(resp_valid), 0);
        chk({tag, "_rid"}, 32'(resp_id), 0);
        chk({tag, "_rhcf"}, 32'(resp_hcf), 0);
        chk({tag, "_rerr"}, 32'(resp_err), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_start"}, 32'(eng_start), 0);
        chk({tag, "_in1"}, 32'(eng_in1), 0);
        chk({tag, "_in2"}, 32'(eng_in2), 0);
        chk({tag, "_abort"}, 32'(eng_abort), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;

        // Engine path, pulse done
        xact(0, 8'd24, 8'd18, 8'd6, 1'b0, 1'b0, 5, 0);
        xact(2, 8'd15, 8'd25, 8'd5, 1'b0, 1'b0, 5, 0);

        // Round robin from reset with all four valid
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        set_req(0, 8'd100, 8'd10);
        set_req(1, 8'd48, 8'd36);
        set_req(2, 8'd17, 8'd5);
        set_req(3, 8'd81, 8'd27);
        rr_step(0, 8'd10);
        rr_step(1, 8'd12);
        rr_step(2, 8'd1);
        rr_step(3, 8'd27);

        // last_grant = 2, then 1 and 3 compete: 3 first
        xact(2, 8'd9, 8'd6, 8'd3, 1'b0, 1'b0, 5, 0);
        @(negedge clk);
        set_req(1, 8'd35, 8'd14);
        set_req(3, 8'd64, 8'd48);
        rr_step(3, 8'd16);
        rr_step(1, 8'd7);

        // Zero-operand bypass
        xact(1, 8'd0, 8'd42, 8'd42, 1'b0, 1'b1, 0, 0);
        xact(1, 8'd0, 8'd0, 8'd0, 1'b1, 1'b1, 0, 0);
        xact(3, 8'd77, 8'd0, 8'd77, 1'b0, 1'b1, 0, 0);

        // Level done: second op starts with done still high from the first
        stub_mode = 1;
        xact(0, 8'd24, 8'd18, 8'd6, 1'b0, 1'b0, 9, 0);
        xact(0, 8'd14, 8'd21, 8'd7, 1'b0, 1'b0, 9, 0);

        // Watchdog timeout, then a normal request
        stub_mode = 2;
        xact(2, 8'd30, 8'd12, 8'd0, 1'b1, 1'b0, 17, 16);
        stub_mode = 0;
        xact(0, 8'd30, 8'd12, 8'd6, 1'b0, 1'b0, 5, 0);

        // Reset during WAIT drops the request and restores requester 0 priority
        stub_mode = 2;
        @(negedge clk);
        set_req(1, 8'd9, 8'd6);
        await_ready(1);
        @(negedge clk);
        req_valid[1] = 1'b0;
        chk("rst_pre_start", 32'(eng_start), 1);
        repeat (3) @(negedge clk);
        chk("rst_pre_busy", 32'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        chk_all_zero("midrst");
        rst = 1'b0;
        stub_mode = 0;
        set_req(0, 8'd12, 8'd8);
        set_req(3, 8'd20, 8'd30);
        rr_step(0, 8'd4);
        rr_step(3, 8'd10);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
